// File: rtl/sm4_dec_iter.sv
// ---------------------------------------------------------------------------
// sm4_dec_iter -- iterative SM4 block decryptor.
//
// Purpose:
//   Expands the 128-bit user key into all 32 round keys (one per cycle) and
//   stores them in a 32x32 register file. It then runs the 32 SM4 rounds on
//   the ciphertext with the round keys applied in reverse order (rk31..rk0).
//   The result is presented through a valid/ready output handshake.
//   Latency from the accept edge to out_valid is 64 cycles, or 32 cycles on
//   a key-cache hit.
//
// Optional feature (compile-time macro SM4_KEY_CACHE_EN):
//   When this macro is defined, the block remembers the last fully expanded
//   key. A request that carries the same key skips key expansion and reuses
//   the round-key file. When it is undefined there are no cache registers.
//
// Parameters:
//   NUM_ROUNDS     SM4 round count; only 32 elaborates.
//   ZERO_IDLE_OUT  1: result_out reads 0 while out_valid=0; 0: holds last result.
//
// Ports:
//   clk         in   1    rising-edge clock
//   reset       in   1    synchronous, active-high reset
//   cipher_in   in   128  ciphertext {X0,X1,X2,X3}, X0 in [127:96]
//   key_in      in   128  user key {MK0,MK1,MK2,MK3}
//   in_valid    in   1    request valid
//   in_ready    out  1    request accepted on in_valid & in_ready
//   result_out  out  128  plaintext {X35,X34,X33,X32}
//   out_valid   out  1    result valid, held until out_ready
//   out_ready   in   1    consumer accepts on out_valid & out_ready
// ---------------------------------------------------------------------------
module sm4_dec_iter #(
    parameter int NUM_ROUNDS    = 32,
    parameter bit ZERO_IDLE_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] result_out,
    output logic         out_valid,
    input  logic         out_ready
);

    if (NUM_ROUNDS != 32) begin : g_bad_rounds
        $error("sm4_dec_iter: NUM_ROUNDS must be 32");
    end

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    // S-box; the entry for index 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};  // (255 - x) * 8
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] l_enc(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    // CK_i byte j = (4i + j) * 7 mod 256
    function automatic logic [31:0] get_cki(input logic [4:0] i);
        logic [7:0] b0, b1, b2, b3;
        b0 = {1'b0, i, 2'd0} * 8'd7;
        b1 = {1'b0, i, 2'd1} * 8'd7;
        b2 = {1'b0, i, 2'd2} * 8'd7;
        b3 = {1'b0, i, 2'd3} * 8'd7;
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] one_round_for_key_exp(input logic [127:0] k, input logic [31:0] ck);
        return {k[95:0], k[127:96] ^ l_key(tau(k[95:64] ^ k[63:32] ^ k[31:0] ^ ck))};
    endfunction

    function automatic logic [127:0] one_round_for_encdec(input logic [127:0] x, input logic [31:0] rk);
        return {x[95:0], x[127:96] ^ l_enc(tau(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk))};
    endfunction

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   result_q, result_d;
    logic [31:0]    rk_q [32];
    logic [31:0]    rk_d [32];
    logic [127:0]   key_round_in;
    logic           accept;
`ifdef SM4_KEY_CACHE_EN
    logic [127:0]   cached_key_q, cached_key_d;
    logic           cache_valid_q, cache_valid_d;
`endif

    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == DONE);
    assign result_out = (ZERO_IDLE_OUT && !out_valid) ? 128'd0 : result_q;

    // The captured user key is FK-whitened on the first expansion cycle only.
    assign key_round_in = (cnt_q == 5'd0) ? (key_q ^ FK) : key_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        key_d    = key_q;
        result_d = result_q;
        rk_d     = rk_q;
`ifdef SM4_KEY_CACHE_EN
        cached_key_d  = cached_key_q;
        cache_valid_d = cache_valid_q;
`endif
        case (state_q)
            KEYEXP: begin
                key_d        = one_round_for_key_exp(key_round_in, get_cki(cnt_q));
                rk_d[cnt_q]  = key_d[31:0];
                if (cnt_q == 5'd31) begin
                    state_d = DEC;  // cnt stays at 31: decryption starts with rk31
`ifdef SM4_KEY_CACHE_EN
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DEC: begin
                data_d = one_round_for_encdec(data_q, rk_q[cnt_q]);
                if (cnt_q == 5'd0) begin
                    result_d = {data_d[31:0], data_d[63:32], data_d[95:64], data_d[127:96]};
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Accept can only fire in IDLE or DONE, so it overrides the case above.
        if (accept) begin
            data_d  = cipher_in;
            key_d   = key_in;
            cnt_d   = 5'd0;
            state_d = KEYEXP;
`ifdef SM4_KEY_CACHE_EN
            if (cache_valid_q && (key_in == cached_key_q)) begin
                cnt_d   = 5'd31;
                state_d = DEC;
            end else begin
                // Cache becomes valid again only once this key is fully expanded.
                cached_key_d  = key_in;
                cache_valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            data_q   <= 128'd0;
            key_q    <= 128'd0;
            result_q <= 128'd0;
`ifdef SM4_KEY_CACHE_EN
            cached_key_q  <= 128'd0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            key_q    <= key_d;
            result_q <= result_d;
`ifdef SM4_KEY_CACHE_EN
            cached_key_q  <= cached_key_d;
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

    // Round-key file: contents are meaningless until written by KEYEXP.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

endmodule
